// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: sums CHUNK bits per clock, LSB chunk first, with the carry
// held in a register between chunks. Valid/ready handshakes on operand and result sides.
module chunked_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NCHUNK - 1);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]   ch_sum;
  logic             msb_cin;

  // Select the chunk addressed by idx; constant slice bounds keep the mux lint-clean.
  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx_q == IdxW'(i)) begin
        a_ch = a_q[i*CHUNK +: CHUNK];
        b_ch = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  assign ch_sum  = {1'b0, a_ch} + {1'b0, b_ch} + (CHUNK+1)'(carry_q);
  // Carry into the top bit of the chunk, recovered from its sum bit.
  assign msb_cin = ch_sum[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub | cin;
          idx_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        for (int unsigned i = 0; i < NCHUNK; i++) begin
          if (idx_q == IdxW'(i)) begin
            s_d[i*CHUNK +: CHUNK] = ch_sum[CHUNK-1:0];
          end
        end
        carry_d = ch_sum[CHUNK];
        idx_d   = idx_q + IdxW'(1);
        if (idx_q == LastIdx) begin
          cout_d  = ch_sum[CHUNK];
          ovf_d   = msb_cin ^ ch_sum[CHUNK];
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && rst_n;
  assign out_valid = (state_q == StDone);
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: arithmetic/timeline model checked every cycle, plus directed
// vectors with hand-computed results, and a CHUNK=WIDTH instance.
module tb_chunked_adder;

  localparam int unsigned W   = 16;
  localparam int unsigned NCH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, cin, sub, out_ready;
  logic [W-1:0] a, b;
  logic         in_ready, out_valid, cout, ovf;
  logic [W-1:0] s;

  logic         in_valid16, cin16, in_ready16, out_valid16, cout16, ovf16;
  logic [W-1:0] a16, b16, s16;

  int n_tests = 0;
  int n_fail  = 0;

  chunked_adder #(.WIDTH(W), .CHUNK(NCH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  chunked_adder #(.WIDTH(W), .CHUNK(W)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a16),
    .b         (b16),
    .cin       (cin16),
    .sub       (1'b0),
    .out_valid (out_valid16),
    .out_ready (1'b1),
    .s         (s16),
    .cout      (cout16),
    .ovf       (ovf16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns {ovf, cout, s} straight from the arithmetic definition.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci, input logic sb);
    logic [W-1:0] yy;
    logic [W:0]   full;
    logic         v;
    yy   = sb ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, sb | ci};
    v    = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
    return {v, full};
  endfunction

  // Expected timeline: busy NCH edges after accept, then result presented until taken.
  int           m_cnt = 0;
  logic         m_valid, m_known, m_cout, m_ovf;
  logic [W-1:0] m_s;
  logic         chk_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt   <= 0;
      m_valid <= 1'b0;
      m_known <= 1'b1;
      m_s     <= '0;
      m_cout  <= 1'b0;
      m_ovf   <= 1'b0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid <= 1'b0;
        m_known <= 1'b0;
      end
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_valid <= 1'b1;
        m_known <= 1'b1;
      end
    end else if (in_valid) begin
      {m_ovf, m_cout, m_s} <= ref_op(a, b, cin, sub);
      m_cnt   <= NCH;
      m_known <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model out_valid", out_valid, m_valid);
      check("model in_ready", in_ready, rst_n && !m_valid && (m_cnt == 0));
      if (m_known) begin
        check("model s", s, m_s);
        check("model cout", cout, m_cout);
        check("model ovf", ovf, m_ovf);
      end
    end
  end

  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic ts, input logic [W-1:0] es,
                        input logic ec, input logic eo);
    int lat;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, lat, NCH);
    check({name, " s"}, s, es);
    check({name, " cout"}, cout, ec);
    check({name, " ovf"}, ovf, eo);
    @(posedge clk); #1;
    check({name, " out_valid drop"}, out_valid, 1'b0);
    check({name, " in_ready back"}, in_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset out_valid", out_valid, 1'b0);
    check("reset s", s, 16'h0000);
    check("reset cout", cout, 1'b0);
    check("reset ovf", ovf, 1'b0);
    check("reset in_ready low", in_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    check("reset in_ready high", in_ready, 1'b1);

    // Single-chunk instance: result one edge after accept.
    @(negedge clk);
    a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b1; in_valid16 = 1'b1;
    check("c16 in_ready", in_ready16, 1'b1);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    check("c16 busy", out_valid16, 1'b0);
    @(posedge clk); #1;
    check("c16 out_valid", out_valid16, 1'b1);
    check("c16 s", s16, 16'h0000);
    check("c16 cout", cout16, 1'b1);
    check("c16 ovf", ovf16, 1'b0);
    @(posedge clk); #1;
    check("c16 drop", out_valid16, 1'b0);

    run_op("ffff+1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("7fff+1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("5-7", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("8000-1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("0f0f+f1+1", 16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);
    run_op("8000+8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Backpressure: result must hold and a stray in_valid must be ignored.
    out_ready = 1'b0;
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp latency", lat, NCH);
    for (int i = 0; i < 10; i++) begin
      check("bp s", s, 16'h2346);
      check("bp cout", cout, 1'b0);
      check("bp ovf", ovf, 1'b0);
      check("bp out_valid", out_valid, 1'b1);
      check("bp in_ready", in_ready, 1'b0);
      if (i == 3) begin
        in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
      end
      if (i == 4) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release out_valid", out_valid, 1'b0);
    check("bp release in_ready", in_ready, 1'b1);

    // Reset two cycles into ADD aborts the operation.
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid reset out_valid", out_valid, 1'b0);
    check("mid reset s", s, 16'h0000);
    check("mid reset cout", cout, 1'b0);
    check("mid reset ovf", ovf, 1'b0);
    check("mid reset in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    check("after reset in_ready", in_ready, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check("aborted result absent", out_valid, 1'b0);

    run_op("3+4", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
